load_store_unit: RTL and testbench

- Sits between the execute stage and data memory; replaces the direct ALU-to-memory connection in the MEM stage.
- Turns load/store instructions (address = alu_result, store data = rs2_data, funct3 size/sign) into word-aligned memory requests with byte enables, using a request/grant plus read-valid handshake.
- Returns sign- or zero-extended load data to writeback.
- Stalls the pipeline while an access is in flight; flags misalignment and bus faults.

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns MEM-stage load/store ops into word-aligned
// memory requests and returns extended load data to writeback.
module load_store_unit #(
  parameter int OPERAND_WIDTH = 32,
  parameter int BUS_TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  input  logic [OPERAND_WIDTH-1:0] alu_result,
  input  logic [OPERAND_WIDTH-1:0] rs2_data,
  input  logic                     ctrl_mem_read,
  input  logic                     ctrl_mem_write,
  input  logic [2:0]               funct3,
  input  logic [4:0]               rd_addr,
  output logic                     lsu_stall,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [OPERAND_WIDTH-1:0] dmem_addr,
  output logic [3:0]               dmem_be,
  output logic [OPERAND_WIDTH-1:0] dmem_wdata,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [OPERAND_WIDTH-1:0] dmem_rdata,
  output logic                     wb_valid,
  output logic [4:0]               wb_rd,
  output logic [OPERAND_WIDTH-1:0] wb_data,
  output logic                     exc_misaligned,
  output logic                     exc_bus_error
);

  localparam int W  = OPERAND_WIDTH;
  localparam int CW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic          accept;
  logic          illegal;
  logic          misaligned;
  logic          timeout;
  logic [3:0]    be_d;
  logic [W-1:0]  wdata_d;
  logic [W-1:0]  lane;
  logic [W-1:0]  ext;

  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [W-1:0]  addr_q;
  logic [W-1:0]  wdata_q;
  logic [W-1:0]  data_q;
  logic [3:0]    be_q;
  logic [4:0]    rd_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          mis_q;
  logic          berr_q;
  logic          ok_q;

  always_comb begin
    accept     = ex_valid & (ctrl_mem_read | ctrl_mem_write);
    illegal    = (ctrl_mem_read & ctrl_mem_write)
               | (funct3 == 3'b011)
               | (funct3[2:1] == 2'b11)
               | (ctrl_mem_write & funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) & alu_result[0])
               | ((funct3[1:0] == 2'b10) & (|alu_result[1:0]));
    timeout    = ((state_q == REQ) | (state_q == WAIT_R))
               & (cnt_q == TMO_LAST);
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = rs2_data;
    unique case (1'b1)
      (funct3[1:0] == 2'b00): begin
        be_d    = 4'b0001 << alu_result[1:0];
        wdata_d = {4{rs2_data[7:0]}};
      end
      (funct3[1:0] == 2'b01): begin
        be_d    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane = dmem_rdata >> {off_q, 3'b000};
    ext  = lane;
    unique case (f3_q)
      3'b000:  ext = {{(W-8){lane[7]}}, lane[7:0]};
      3'b001:  ext = {{(W-16){lane[15]}}, lane[15:0]};
      3'b100:  ext = {{(W-8){1'b0}}, lane[7:0]};
      3'b101:  ext = {{(W-16){1'b0}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = (illegal | misaligned) ? DONE : REQ;
      end
      REQ: begin
        if (timeout)
          state_d = DONE;
        else if (dmem_gnt)
          state_d = we_q ? DONE : WAIT_R;
      end
      WAIT_R: begin
        if (timeout | dmem_rvalid)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= ctrl_mem_write;
            addr_q  <= {alu_result[W-1:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_addr;
            f3_q    <= funct3;
            off_q   <= alu_result[1:0];
            berr_q  <= illegal;
            mis_q   <= ~illegal & misaligned;
            ok_q    <= 1'b0;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout)
            berr_q <= 1'b1;
        end
        WAIT_R: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout) begin
            berr_q <= 1'b1;
          end else if (dmem_rvalid) begin
            ok_q   <= 1'b1;
            data_q <= ext;
          end
        end
        DONE:    cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

  // Reset forces every output low, even while EX still presents an op.
  assign lsu_stall      = ~rst & ((state_q == REQ) | (state_q == WAIT_R)
                        | ((state_q == IDLE) & accept));
  assign dmem_req       = (state_q == REQ);
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign wb_valid       = (state_q == DONE) & ok_q;
  assign wb_rd          = rd_q;
  assign wb_data        = data_q;
  assign exc_misaligned = (state_q == DONE) & mis_q;
  assign exc_bus_error  = (state_q == DONE) & berr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level memory model,
// randomized bus timing, directed latency/boundary cases.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic        ctrl_mem_read;
  logic        ctrl_mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic        lsu_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_misaligned;
  logic        exc_bus_error;

  always #5 clk = ~clk;

  load_store_unit #(
    .OPERAND_WIDTH(32),
    .BUS_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ex_valid(ex_valid),
    .alu_result(alu_result),
    .rs2_data(rs2_data),
    .ctrl_mem_read(ctrl_mem_read),
    .ctrl_mem_write(ctrl_mem_write),
    .funct3(funct3),
    .rd_addr(rd_addr),
    .lsu_stall(lsu_stall),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .exc_misaligned(exc_misaligned),
    .exc_bus_error(exc_bus_error)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0]  rmem [int];
  logic [31:0] dev [int];

  bit rand_dly = 0;
  bit never_gnt = 0;
  bit junk_rv = 0;
  int gnt_dly = 0;
  int rv_dly = 1;

  function automatic logic [31:0] init_word(int a);
    logic [31:0] x;
    x = a;
    return (x * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [7:0] ref_byte(int a);
    logic [31:0] w;
    if (rmem.exists(a))
      return rmem[a];
    w = init_word(a & ~3);
    return w[8*(a & 3) +: 8];
  endfunction

  function automatic logic [31:0] dev_word(int wa);
    if (dev.exists(wa))
      return dev[wa];
    return init_word(wa);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_stall"}, 32'(lsu_stall), 0);
    chk({tag, "_req"}, 32'(dmem_req), 0);
    chk({tag, "_we"}, 32'(dmem_we), 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_be"}, 32'(dmem_be), 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_wbv"}, 32'(wb_valid), 0);
    chk({tag, "_wbrd"}, 32'(wb_rd), 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_mis"}, 32'(exc_misaligned), 0);
    chk({tag, "_berr"}, 32'(exc_bus_error), 0);
  endtask

  // Memory device: grant after gnt_dly cycles, read data rv_dly later.
  initial begin
    int          wcnt;
    int          rv_cnt;
    int          wa;
    bit          rv_pend;
    logic [31:0] w;
    logic [31:0] rv_word;
    dmem_gnt    = 0;
    dmem_rvalid = 0;
    dmem_rdata  = 0;
    wcnt        = 0;
    rv_cnt      = 0;
    rv_pend     = 0;
    rv_word     = 0;
    forever begin
      @(posedge clk);
      #1;
      dmem_gnt    = 0;
      dmem_rvalid = 0;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          dmem_rvalid = 1;
          dmem_rdata  = rv_word;
          rv_pend     = 0;
        end else begin
          rv_cnt--;
        end
      end else if (junk_rv && $urandom_range(0, 3) == 0) begin
        dmem_rvalid = 1;
        dmem_rdata  = $urandom;
      end
      if (dmem_req && !never_gnt) begin
        if (wcnt >= gnt_dly) begin
          dmem_gnt = 1;
          wcnt     = 0;
          wa       = int'(dmem_addr);
          if (dmem_we) begin
            w = dev_word(wa);
            for (int b = 0; b < 4; b++)
              if (dmem_be[b]) w[8*b +: 8] = dmem_wdata[8*b +: 8];
            dev[wa] = w;
          end else begin
            rv_pend = 1;
            rv_cnt  = rv_dly - 1;
            rv_word = dev_word(wa);
          end
          if (rand_dly) begin
            gnt_dly = $urandom_range(0, 3);
            rv_dly  = $urandom_range(1, 3);
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT handshakes or pulses.
  initial begin
    req_t        e;
    res_t        r;
    bit          pv;
    logic [31:0] pa;
    logic [31:0] pw;
    logic [3:0]  pb;
    logic        pwe;
    int          k;
    int          act;
    pv = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
      end else begin
        if (dmem_req)
          chk("addr_align", 32'(dmem_addr[1:0]), 0);
        if (pv) begin
          chk("req_hold", 32'(dmem_req | exc_bus_error), 1);
          if (dmem_req) begin
            chk("addr_hold", dmem_addr, pa);
            chk("be_hold", 32'(dmem_be), 32'(pb));
            chk("wdata_hold", dmem_wdata, pw);
            chk("we_hold", 32'(dmem_we), 32'(pwe));
          end
        end
        pv  = dmem_req && !dmem_gnt;
        pa  = dmem_addr;
        pb  = dmem_be;
        pw  = dmem_wdata;
        pwe = dmem_we;
        if (dmem_req && dmem_gnt) begin
          if (req_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_req: got addr %h expected none",
                     dmem_addr);
          end else begin
            e = req_q.pop_front();
            chk("req_we", 32'(dmem_we), 32'(e.we));
            chk("req_addr", dmem_addr, e.addr);
            chk("req_be", 32'(dmem_be), 32'(e.be));
            if (e.we)
              chk("req_wdata", dmem_wdata, e.wdata);
          end
        end
        k = int'(wb_valid) + int'(exc_misaligned) + int'(exc_bus_error);
        if (k != 0) begin
          chk("one_pulse", k, 1);
          if (res_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got %0d pulses expected none",
                     k);
          end else begin
            r   = res_q.pop_front();
            act = wb_valid ? 0 : (exc_misaligned ? 1 : 2);
            chk("result_kind", act, r.kind);
            if (r.kind == 0) begin
              chk("wb_rd", 32'(wb_rd), 32'(r.rd));
              chk("wb_data", wb_data, r.data);
            end
          end
        end
      end
    end
  end

  // Predicts the outcome from the ISA rules, then presents the op until
  // the pipeline is released; n is the index of the release cycle.
  task automatic run_op(input bit r, input bit w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input bit tmo,
                        input bit ovr, input logic [31:0] ovr_val,
                        output int n);
    int          sz;
    res_t        res;
    req_t        rq;
    logic [31:0] v;
    logic [3:0]  be;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    res.rd   = rd;
    res.data = 0;
    if (tmo || (r && w) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 ||
        (w && f3[2])) begin
      res.kind = 2;
      res_q.push_back(res);
    end else if ((int'(a) % sz) != 0) begin
      res.kind = 1;
      res_q.push_back(res);
    end else begin
      be = (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
      rq.we    = w;
      rq.addr  = a & ~32'd3;
      rq.be    = be << a[1:0];
      rq.wdata = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
      req_q.push_back(rq);
      if (r) begin
        v = 0;
        for (int i = sz - 1; i >= 0; i--)
          v = (v << 8) | 32'(ref_byte(int'(a) + i));
        if (!f3[2] && sz < 4 && v[8*sz-1])
          v = v | (32'hFFFFFFFF << (8 * sz));
        res.kind = 0;
        res.data = ovr ? ovr_val : v;
        res_q.push_back(res);
      end else begin
        for (int i = 0; i < sz; i++)
          rmem[int'(a) + i] = d[8*i +: 8];
      end
    end
    @(posedge clk);
    #1;
    ex_valid       = 1;
    ctrl_mem_read  = r;
    ctrl_mem_write = w;
    funct3         = f3;
    alu_result     = a;
    rs2_data       = d;
    rd_addr        = rd;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!lsu_stall) break;
      n++;
      if (n > 100) begin
        n_chk++;
        n_fail++;
        $display("FAIL op_timeout: got stall after %0d cycles expected release",
                 n);
        break;
      end
    end
  endtask

  task automatic idle(int k);
    @(posedge clk);
    #1;
    ex_valid       = 0;
    ctrl_mem_read  = 0;
    ctrl_mem_write = 0;
    repeat (k - 1) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    req_t        rq;
    bit          r;
    bit          w;
    int          x;
    logic [31:0] a;
    rst            = 1;
    ex_valid       = 0;
    ctrl_mem_read  = 0;
    ctrl_mem_write = 0;
    funct3         = 0;
    alu_result     = 0;
    rs2_data       = 0;
    rd_addr        = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 0;

    run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, n);
    chk("sw_latency", n, 2);
    run_op(1, 0, 3'b010, 32'h100, 0, 5'd3, 0, 1, 32'hDEADBEEF, n);
    chk("lw_latency", n, 3);
    run_op(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0, 0, n);
    chk("sb_latency", n, 2);

    run_op(0, 1, 3'b010, 32'h0, 32'h80FF7F80, 0, 0, 0, 0, n);
    run_op(1, 0, 3'b000, 32'h0, 0, 5'd1, 0, 1, 32'hFFFFFF80, n);
    run_op(1, 0, 3'b100, 32'h0, 0, 5'd2, 0, 1, 32'h00000080, n);
    run_op(1, 0, 3'b001, 32'h2, 0, 5'd4, 0, 1, 32'hFFFF80FF, n);
    run_op(1, 0, 3'b101, 32'h2, 0, 5'd5, 0, 1, 32'h000080FF, n);
    chk("lhu_latency", n, 3);

    run_op(1, 0, 3'b001, 32'h101, 0, 5'd9, 0, 0, 0, n);
    chk("mis_latency", n, 1);
    run_op(1, 0, 3'b011, 32'h100, 0, 5'd9, 0, 0, 0, n);
    chk("ill_f3_latency", n, 1);
    run_op(0, 1, 3'b100, 32'h100, 32'h1234, 0, 0, 0, 0, n);
    chk("ill_st_latency", n, 1);
    run_op(1, 1, 3'b010, 32'h100, 32'h1234, 5'd9, 0, 0, 0, n);
    chk("ill_rw_latency", n, 1);

    gnt_dly = 3;
    rv_dly  = 2;
    run_op(1, 0, 3'b010, 32'h100, 0, 5'd11, 0, 1, 32'hDEADBEEF, n);
    chk("slow_latency", n, 7);
    gnt_dly = 0;
    rv_dly  = 1;

    never_gnt = 1;
    run_op(1, 0, 3'b010, 32'h80, 0, 5'd2, 1, 0, 0, n);
    chk("tmo_latency", n, 9);
    chk("tmo_req_drop", 32'(dmem_req), 0);
    never_gnt = 0;

    idle(2);
    rv_dly   = 3;
    rq.we    = 0;
    rq.addr  = 32'h40;
    rq.be    = 4'b1111;
    rq.wdata = 0;
    req_q.push_back(rq);
    @(posedge clk);
    #1;
    ex_valid       = 1;
    ctrl_mem_read  = 1;
    ctrl_mem_write = 0;
    funct3         = 3'b010;
    alu_result     = 32'h40;
    rs2_data       = 0;
    rd_addr        = 5'd6;
    repeat (3) @(negedge clk);
    chk("waitr_stall", 32'(lsu_stall), 1);
    chk("waitr_req", 32'(dmem_req), 0);
    #2;
    rst            = 1;
    ex_valid       = 0;
    ctrl_mem_read  = 0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    rv_dly = 1;
    run_op(1, 0, 3'b010, 32'h40, 0, 5'd6, 0, 0, 0, n);
    chk("post_rst_latency", n, 3);

    rand_dly = 1;
    junk_rv  = 1;
    repeat (300) begin
      x = $urandom_range(0, 15);
      r = (x < 8);
      w = (x == 0) || (x >= 8);
      a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 2) == 0)
        a = a + 32'($urandom_range(1, 3));
      run_op(r, w, 3'($urandom_range(0, 7)), a, $urandom,
             5'($urandom_range(0, 31)), 0, 0, 0, n);
      chk("rand_stalled", 32'(n >= 1), 1);
      if ($urandom_range(0, 2) == 0)
        idle($urandom_range(1, 3));
    end
    junk_rv = 0;
    idle(20);
    chk("req_q_empty", req_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
